// File: rtl/cnn_result_writer.sv
// Packs accelerator result elements into 64-bit words in a RAM for a RISC-V bus reader.
// Optional macro CNN_RESULT_RELU_EN: negative elements (bit 31 set) are stored as zero.
module cnn_result_writer #(
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MAX_RESULTS    = 4096
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic                          clearIn,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          validIn,
    input  logic                          lastIn,
    output logic                          readyOut,
    input  logic [BUS_ADDR_WIDTH-1:0]     addrIn,
    input  logic                          rdEnIn,
    output logic [BUS_DATA_WIDTH-1:0]     rdDataOut,
    output logic                          rdAckOut,
    output logic [$clog2(MAX_RESULTS):0]  countOut,
    output logic                          doneOut,
    output logic                          overflowOut
);
    localparam int DEPTH = MAX_RESULTS / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(MAX_RESULTS) + 1;

    typedef enum logic [1:0] {EMPTY, HALF, FLUSH, DONE} state_t;

    state_t                    state_q, state_d;
    logic [AW:0]               wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     lo_q, lo_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic                      rd_ack_q;
    logic [BUS_DATA_WIDTH-1:0] rd_data_q;
    logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];

    logic                      full, accept, we;
    logic [BUS_DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0]     elem;
    logic [AW-1:0]             rd_idx;
    logic                      unused_addr_bits;

    assign full     = (count_q == CW'(MAX_RESULTS));
    assign readyOut = ((state_q == EMPTY) || (state_q == HALF)) && !full;
    assign accept   = validIn && readyOut;
    assign rd_idx   = addrIn[AW+2:3];
    assign unused_addr_bits = ^{addrIn[BUS_ADDR_WIDTH-1:AW+3], addrIn[2:0]};

`ifdef CNN_RESULT_RELU_EN
    assign elem = dataIn[DATA_WIDTH-1] ? '0 : dataIn;
`else
    assign elem = dataIn;
`endif

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        lo_d      = lo_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        we        = 1'b0;
        wdata     = {elem, lo_q};

        if (validIn && full && (state_q != DONE))
            ovf_d = 1'b1;

        case (state_q)
            EMPTY: if (accept) begin
                lo_d    = elem;
                count_d = count_q + CW'(1);
                state_d = lastIn ? FLUSH : HALF;
            end
            HALF: if (accept) begin
                we        = 1'b1;
                wr_addr_d = wr_addr_q + (AW+1)'(1);
                count_d   = count_q + CW'(1);
                state_d   = lastIn ? DONE : EMPTY;
            end
            FLUSH: begin
                we        = 1'b1;
                wdata     = {{DATA_WIDTH{1'b0}}, lo_q};
                wr_addr_d = wr_addr_q + (AW+1)'(1);
                state_d   = DONE;
            end
            default: ;
        endcase

        // Clear wins over any same-cycle accept or flush; the element is dropped.
        if (clearIn) begin
            state_d   = EMPTY;
            wr_addr_d = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            we        = 1'b0;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q   <= EMPTY;
            wr_addr_q <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // RAM is never reset; wr_addr_q's extra MSB keeps it from wrapping when full.
    always_ff @(posedge clkIn) begin
        if (we)
            mem[wr_addr_q[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rdEnIn;
            if (rdEnIn)
                rd_data_q <= mem[rd_idx];
        end
    end

    assign rdAckOut    = rd_ack_q;
    assign rdDataOut   = rd_data_q;
    assign countOut    = count_q;
    assign doneOut     = (state_q == DONE);
    assign overflowOut = ovf_q;

endmodule

// File: tb/tb_cnn_result_writer.sv
// Bench for cnn_result_writer (MAX_RESULTS=8): directed scenarios plus randomized result sets.
module tb_cnn_result_writer;
    localparam int MAXR = 8;

    logic        clkIn = 1'b0;
    logic        rstIn, clearIn, validIn, lastIn, rdEnIn;
    logic [31:0] dataIn, addrIn;
    logic        readyOut, rdAckOut, doneOut, overflowOut;
    logic [63:0] rdDataOut;
    logic [3:0]  countOut;

    int nvec = 0;
    int nerr = 0;

    // Reference model: words built from pairs of accepted elements, persisting across clears.
    logic [63:0] m_mem [MAXR/2];
    logic [31:0] m_lo;
    int          m_n;

    cnn_result_writer #(
        .DATA_WIDTH(32), .BUS_ADDR_WIDTH(32), .BUS_DATA_WIDTH(64), .MAX_RESULTS(MAXR)
    ) dut (
        .clkIn(clkIn), .rstIn(rstIn), .clearIn(clearIn), .dataIn(dataIn),
        .validIn(validIn), .lastIn(lastIn), .readyOut(readyOut), .addrIn(addrIn),
        .rdEnIn(rdEnIn), .rdDataOut(rdDataOut), .rdAckOut(rdAckOut), .countOut(countOut),
        .doneOut(doneOut), .overflowOut(overflowOut)
    );

    always #5 clkIn = ~clkIn;

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef CNN_RESULT_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int t = 0;
        validIn = 1'b1; dataIn = d; lastIn = last;
        while (!readyOut && t < 20) begin step(); t++; end
        nvec++;
        if (!readyOut) begin
            nerr++;
            $display("FAIL send_ready: readyOut=%0b required 1 within 20 cycles", readyOut);
        end else begin
            step();
            m_n++;
            if (m_n % 2 == 0) m_mem[m_n/2 - 1] = {relu(d), relu(m_lo)};
            else begin
                m_lo = d;
                if (last) m_mem[(m_n-1)/2] = {32'h0, relu(d)};
            end
            nvec++;
            if (countOut !== 4'(m_n)) begin
                nerr++;
                $display("FAIL send_count: countOut=%0d required %0d", countOut, m_n);
            end
        end
        validIn = 1'b0; lastIn = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [63:0] exp, input string nm);
        addrIn = $urandom();
        addrIn[4:3] = idx[1:0];
        rdEnIn = 1'b1;
        step();
        rdEnIn = 1'b0;
        nvec++;
        if (rdAckOut !== 1'b1 || rdDataOut !== exp) begin
            nerr++;
            $display("FAIL %s_read: ack=%0b data=%h required ack=1 data=%h", nm, rdAckOut, rdDataOut, exp);
        end
        step();
        nvec++;
        if (rdAckOut !== 1'b0 || rdDataOut !== exp) begin
            nerr++;
            $display("FAIL %s_hold: ack=%0b data=%h required ack=0 data=%h", nm, rdAckOut, rdDataOut, exp);
        end
    endtask

    task automatic do_clear();
        clearIn = 1'b1;
        step();
        clearIn = 1'b0;
        m_n = 0;
        nvec++;
        if (countOut !== 0 || readyOut !== 1'b1 || doneOut !== 1'b0 || overflowOut !== 1'b0) begin
            nerr++;
            $display("FAIL clear: cnt=%0d rdy=%0b done=%0b ovf=%0b required 0/1/0/0",
                     countOut, readyOut, doneOut, overflowOut);
        end
    endtask

    task automatic test_reset();
        rstIn = 1'b1; clearIn = 1'b0; validIn = 1'b0; lastIn = 1'b0;
        rdEnIn = 1'b0; dataIn = '0; addrIn = '0;
        m_n = 0; m_lo = '0;
        for (int i = 0; i < MAXR/2; i++) m_mem[i] = '0;
        #12;
        nvec++;
        if (countOut !== 0 || readyOut !== 1'b1 || doneOut !== 1'b0 || overflowOut !== 1'b0 ||
            rdAckOut !== 1'b0 || rdDataOut !== 64'h0) begin
            nerr++;
            $display("FAIL reset: cnt=%0d rdy=%0b done=%0b ovf=%0b ack=%0b data=%h required 0/1/0/0/0/0",
                     countOut, readyOut, doneOut, overflowOut, rdAckOut, rdDataOut);
        end
        @(negedge clkIn);
        rstIn = 1'b0;
        step();
        nvec++;
        if (countOut !== 0 || readyOut !== 1'b1 || doneOut !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: cnt=%0d rdy=%0b done=%0b required 0/1/0", countOut, readyOut, doneOut);
        end
    endtask

    task automatic test_four_elements();
        do_clear();
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b1);
        nvec++;
        if (doneOut !== 1'b1 || countOut !== 4'd4 || readyOut !== 1'b0) begin
            nerr++;
            $display("FAIL four_done: done=%0b cnt=%0d rdy=%0b required 1/4/0", doneOut, countOut, readyOut);
        end
        rd(0, 64'h400000003F800000, "four_w0");
        rd(1, 64'h4080000040400000, "four_w1");
    endtask

    task automatic test_flush();
        logic [31:0] e [3];
        do_clear();
        for (int i = 0; i < 3; i++) e[i] = $urandom();
        send(e[0], 1'b0);
        send(e[1], 1'b0);
        send(e[2], 1'b1);
        nvec++;
        if (doneOut !== 1'b0 || readyOut !== 1'b0) begin
            nerr++;
            $display("FAIL flush_cycle: done=%0b rdy=%0b required 0/0", doneOut, readyOut);
        end
        step();
        nvec++;
        if (doneOut !== 1'b1 || countOut !== 4'd3) begin
            nerr++;
            $display("FAIL flush_done: done=%0b cnt=%0d required 1/3", doneOut, countOut);
        end
        rd(0, {relu(e[1]), relu(e[0])}, "flush_w0");
        rd(1, {32'h0, relu(e[2])}, "flush_w1");
    endtask

    task automatic test_relu();
        do_clear();
        send(32'hBF800000, 1'b0);
        send(32'h40A00000, 1'b1);
`ifdef CNN_RESULT_RELU_EN
        rd(0, 64'h40A0000000000000, "relu_w0");
`else
        rd(0, 64'h40A00000BF800000, "relu_w0");
`endif
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < MAXR; i++) send($urandom(), 1'b0);
        nvec++;
        if (readyOut !== 1'b0 || countOut !== 4'd8 || overflowOut !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_full: rdy=%0b cnt=%0d ovf=%0b required 0/8/0", readyOut, countOut, overflowOut);
        end
        validIn = 1'b1; dataIn = $urandom();
        step();
        validIn = 1'b0;
        step();
        nvec++;
        if (overflowOut !== 1'b1 || countOut !== 4'd8 || readyOut !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_sticky: ovf=%0b cnt=%0d rdy=%0b required 1/8/0", overflowOut, countOut, readyOut);
        end
        for (int w = 0; w < MAXR/2; w++) rd(w, m_mem[w], "ovf_word");
        do_clear();
    endtask

    task automatic test_clear_collision();
        logic [31:0] c, d;
        do_clear();
        send($urandom(), 1'b0);
        clearIn = 1'b1; validIn = 1'b1; dataIn = $urandom();
        step();
        clearIn = 1'b0; validIn = 1'b0;
        m_n = 0;
        nvec++;
        if (countOut !== 0 || readyOut !== 1'b1 || doneOut !== 1'b0) begin
            nerr++;
            $display("FAIL collide_state: cnt=%0d rdy=%0b done=%0b required 0/1/0", countOut, readyOut, doneOut);
        end
        c = $urandom(); d = $urandom();
        send(c, 1'b0);
        send(d, 1'b0);
        rd(0, {relu(d), relu(c)}, "collide_w0");
    endtask

    task automatic test_async_reset();
        logic [31:0] e, f;
        do_clear();
        e = $urandom(); f = $urandom();
        send(e, 1'b0);
        send(f, 1'b0);
        rd(0, {relu(f), relu(e)}, "arst_pre");
        send($urandom(), 1'b0);
        #2 rstIn = 1'b1;
        #1;
        nvec++;
        if (countOut !== 0 || readyOut !== 1'b1 || doneOut !== 1'b0 || overflowOut !== 1'b0 ||
            rdAckOut !== 1'b0 || rdDataOut !== 64'h0) begin
            nerr++;
            $display("FAIL arst_outputs: cnt=%0d rdy=%0b done=%0b ovf=%0b ack=%0b data=%h required 0/1/0/0/0/0",
                     countOut, readyOut, doneOut, overflowOut, rdAckOut, rdDataOut);
        end
        #2 rstIn = 1'b0;
        m_n = 0;
        step();
        rd(0, {relu(f), relu(e)}, "arst_keep");
    endtask

    task automatic test_random_sets();
        for (int r = 0; r < 8; r++) begin
            int n;
            bit last;
            int nw;
            do_clear();
            n = $urandom_range(MAXR, 1);
            last = $urandom_range(1, 0);
            for (int i = 0; i < n; i++) send($urandom(), (last && i == n-1));
            if (last && (n % 2 == 1)) step();
            nvec++;
            if (doneOut !== last || readyOut !== (!last && n < MAXR) || countOut !== 4'(n)) begin
                nerr++;
                $display("FAIL rand_state: n=%0d last=%0b done=%0b rdy=%0b cnt=%0d", n, last, doneOut, readyOut, countOut);
            end
            nw = last ? (n + 1) / 2 : n / 2;
            for (int w = 0; w < nw; w++) rd(w, m_mem[w], "rand_word");
        end
    endtask

    initial begin
        test_reset();
        test_four_elements();
        test_flush();
        test_relu();
        test_overflow();
        test_clear_collision();
        test_async_reset();
        test_random_sets();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cnn_result_writer.md
CNN_RESULT_WRITER -- requirements
Module: cnn_result_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one float result element.
REQ-002 SHALL have parameter BUS_ADDR_WIDTH, default 32, meaning the RISC-V bus byte-address width.
REQ-003 SHALL have parameter BUS_DATA_WIDTH, default 64, meaning the RISC-V bus data width, fixed at 2*DATA_WIDTH.
REQ-004 SHALL have parameter MAX_RESULTS, default 4096, meaning the result capacity in elements; RAM depth is MAX_RESULTS/2 words.
REQ-005 SHALL have port clkIn, input, 1 bit: the single clock.
REQ-006 SHALL have port rstIn, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port clearIn, input, 1 bit: synchronous restart of collection.
REQ-008 SHALL have port dataIn, input, DATA_WIDTH: result element from the accelerator output FIFO.
REQ-009 SHALL have port validIn, input, 1 bit: dataIn is valid.
REQ-010 SHALL have port lastIn, input, 1 bit: marks the final element of a result set.
REQ-011 SHALL have port readyOut, output, 1 bit: element can be accepted this cycle.
REQ-012 SHALL have port addrIn, input, BUS_ADDR_WIDTH: bus byte address for reads.
REQ-013 SHALL have port rdEnIn, input, 1 bit: bus read strobe.
REQ-014 SHALL have port rdDataOut, output, BUS_DATA_WIDTH: bus read data.
REQ-015 SHALL have port rdAckOut, output, 1 bit: rdDataOut is valid.
REQ-016 SHALL have port countOut, output, clog2(MAX_RESULTS)+1 bits: elements accepted since the last clear.
REQ-017 SHALL have port doneOut, output, 1 bit: the result set is complete.
REQ-018 SHALL have port overflowOut, output, 1 bit: sticky flag for validIn asserted while full.

Function
REQ-019 SHALL implement states EMPTY (no pending half-word), HALF (low element held in loR), FLUSH and DONE.
REQ-020 SHALL accept an element only in a cycle where validIn and readyOut are both high.
REQ-021 SHALL drive readyOut high only in EMPTY or HALF, and only when countOut < MAX_RESULTS.
REQ-022 In EMPTY, an accept SHALL store the element in loR and go to HALF; if lastIn is also high, it SHALL go to FLUSH instead.
REQ-023 In HALF, an accept SHALL write {dataIn, loR} to RAM[wrAddr], increment wrAddr and go to EMPTY; if lastIn is also high, it SHALL go to DONE instead.
REQ-024 FLUSH SHALL last one cycle: write {32'h0, loR} to RAM[wrAddr], increment wrAddr, then go to DONE.
REQ-025 In DONE, doneOut SHALL be 1 and readyOut 0, and the block SHALL stay in DONE until clearIn.
REQ-026 The first element of each pair SHALL occupy bits 31:0 of the word; the second SHALL occupy bits 63:32.
REQ-027 countOut SHALL increment by 1 on each accept and SHALL saturate at MAX_RESULTS.
REQ-028 Reaching countOut == MAX_RESULTS with the last word written SHALL hold the state with readyOut=0; the block SHALL not wrap wrAddr.
REQ-029 validIn high while countOut == MAX_RESULTS and not in DONE SHALL set overflowOut, which stays set until clearIn or reset.
REQ-030 clearIn SHALL, in any state, return to EMPTY and zero wrAddr, countOut, doneOut and overflowOut; it SHALL take priority over an accept in the same cycle, discarding that element.
REQ-031 A bus read SHALL use word index addrIn[clog2(MAX_RESULTS/2)+2:3] and ignore addrIn[2:0].
REQ-032 A bus read SHALL return rdDataOut with rdAckOut as a one-cycle pulse exactly one cycle after rdEnIn.
REQ-033 Reads SHALL be permitted in any state; a read and a write to the same word in the same cycle SHALL return the old data.
REQ-034 rdDataOut SHALL hold its last value when rdAckOut is 0.

Reset
REQ-035 rstIn high SHALL asynchronously force state EMPTY, and wrAddr, loR, countOut, doneOut, overflowOut, rdAckOut and rdDataOut to 0; readyOut follows state (1).
REQ-036 RAM contents SHALL NOT be cleared by rstIn or clearIn.

Configuration
REQ-037 With macro CNN_RESULT_RELU_EN defined, any element with bit 31 = 1 (including -0.0) SHALL be stored as 32'h0; otherwise the value is stored unchanged.
REQ-038 Without CNN_RESULT_RELU_EN, all elements SHALL be stored bit-exact.

Verification
REQ-039 Scenario 1: 4 elements 1.0, 2.0, 3.0, 4.0 with lastIn on the 4th, then reads of addresses 0x0 and 0x8 -> 0x400000003F800000 and 0x4080000040400000, doneOut=1, countOut=4.
REQ-040 Scenario 2: 3 elements with lastIn on the 3rd -> FLUSH writes word 1 = {32'h0, elem3}, doneOut asserts 2 cycles after the 3rd accept.
REQ-041 Scenario 3: with CNN_RESULT_RELU_EN defined, send -1.0 (0xBF800000) and 5.0 -> word 0 = 0x40A0000000000000; with the macro undefined -> 0x40A00000BF800000.
REQ-042 Scenario 4: with MAX_RESULTS=8, send 9 elements and no lastIn -> readyOut=0 after the 8th accept, overflowOut=1, countOut=8, and words 0-3 intact.
REQ-043 Scenario 5: clearIn and validIn in the same cycle while in HALF -> state EMPTY, countOut=0, element dropped, and the next pair is written at word 0.
REQ-044 Scenario 6: rstIn pulsed asynchronously mid-pair -> all outputs read 0 immediately except readyOut=1, and a prior word 0 is still readable.
